// File: rtl/apb_req_arbiter_if.sv
// Bundle of the requester-side handshake and the APB completer-side bus for apb_req_arbiter.
// master: the arbiter's view; slave: the view of the requesters and completer around it.
interface apb_req_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   req_write;
    logic [NREQ*8-1:0] req_addr;
    logic [NREQ*8-1:0] req_wdata;
    logic [NREQ-1:0]   rsp_valid;
    logic [7:0]        rsp_rdata;
    logic              rsp_err;
    logic              busy;

    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [7:0]        PADDR;
    logic [7:0]        PWDATA;
    logic [7:0]        PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        input  PRDATA, PREADY, PSLVERR,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        output PRDATA, PREADY, PSLVERR,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that serialises NREQ local requesters onto one APB completer.
// Define APB_ARB_TIMEOUT_EN to abort ACCESS after TIMEOUT cycles without PREADY.
module apb_req_arbiter #(
    parameter int NREQ = 2
`ifdef APB_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 16
`endif
) (
    input logic               PCLK,
    input logic               PRESET,
    apb_req_arbiter_if.master bus
);
    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic            pwrite_q, pwrite_d;
    logic [7:0]      paddr_q, paddr_d;
    logic [7:0]      pwdata_q, pwdata_d;
    logic            psel_q, psel_d;
    logic            penable_q, penable_d;
    logic            busy_q, busy_d;
    logic [NREQ-1:0] rspValid_q, rspValid_d;
    logic [7:0]      rspRdata_q, rspRdata_d;
    logic            rspErr_q, rspErr_d;

    logic            found;
    logic [PW-1:0]   winner;
    logic [NREQ-1:0] reqReady;

`ifdef APB_ARB_TIMEOUT_EN
    logic [7:0]      toCnt_q, toCnt_d;
`endif

    // Search starts one past the last grant so the previous owner ranks last.
    always_comb begin
        found  = 1'b0;
        winner = ptr_q;
        for (int i = 1; i <= NREQ; i++) begin
            if (!found && bus.req_valid[(int'(ptr_q) + i) % NREQ]) begin
                found  = 1'b1;
                winner = PW'((int'(ptr_q) + i) % NREQ);
            end
        end
    end

    always_comb begin
        reqReady = '0;
        if (state_q == IDLE && found) begin
            reqReady[winner] = 1'b1;
        end
    end

    // Output registers are loaded with the values belonging to the next state.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        pwrite_d   = pwrite_q;
        paddr_d    = paddr_q;
        pwdata_d   = pwdata_q;
        psel_d     = 1'b0;
        penable_d  = 1'b0;
        busy_d     = 1'b0;
        rspValid_d = '0;
        rspRdata_d = 8'h00;
        rspErr_d   = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
        toCnt_d    = toCnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d  = SETUP;
                    ptr_d    = winner;
                    pwrite_d = bus.req_write[winner];
                    paddr_d  = bus.req_addr[{winner, 3'b000} +: 8];
                    pwdata_d = bus.req_wdata[{winner, 3'b000} +: 8];
                    psel_d   = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                psel_d    = 1'b1;
                penable_d = 1'b1;
                busy_d    = 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
                toCnt_d   = 8'h00;
`endif
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    state_d            = RESP;
                    busy_d             = 1'b1;
                    rspValid_d[ptr_q]  = 1'b1;
                    rspRdata_d         = pwrite_q ? 8'h00 : bus.PRDATA;
                    rspErr_d           = bus.PSLVERR;
`ifdef APB_ARB_TIMEOUT_EN
                end else if (toCnt_q == 8'(TIMEOUT - 1)) begin
                    state_d            = RESP;
                    busy_d             = 1'b1;
                    rspValid_d[ptr_q]  = 1'b1;
                    rspErr_d           = 1'b1;
                end else begin
                    psel_d    = 1'b1;
                    penable_d = 1'b1;
                    busy_d    = 1'b1;
                    toCnt_d   = toCnt_q + 8'h01;
                end
`else
                end else begin
                    psel_d    = 1'b1;
                    penable_d = 1'b1;
                    busy_d    = 1'b1;
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q    <= IDLE;
            ptr_q      <= PW'(NREQ - 1);
            pwrite_q   <= 1'b0;
            paddr_q    <= 8'h00;
            pwdata_q   <= 8'h00;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            busy_q     <= 1'b0;
            rspValid_q <= '0;
            rspRdata_q <= 8'h00;
            rspErr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            pwrite_q   <= pwrite_d;
            paddr_q    <= paddr_d;
            pwdata_q   <= pwdata_d;
            psel_q     <= psel_d;
            penable_q  <= penable_d;
            busy_q     <= busy_d;
            rspValid_q <= rspValid_d;
            rspRdata_q <= rspRdata_d;
            rspErr_q   <= rspErr_d;
        end
    end

`ifdef APB_ARB_TIMEOUT_EN
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            toCnt_q <= 8'h00;
        end else begin
            toCnt_q <= toCnt_d;
        end
    end
`endif

    assign bus.req_ready = reqReady;
    assign bus.rsp_valid = rspValid_q;
    assign bus.rsp_rdata = rspRdata_q;
    assign bus.rsp_err   = rspErr_q;
    assign bus.busy      = busy_q;
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;

endmodule
